// File: rtl/mdu_iter.sv
// Iterative radix-2 multiply/divide unit: shift-add multiply, restoring divide,
// MADD/MSUB accumulate into {HI,LO}, start/ready handshake with annul.
module mdu_iter #(
    parameter int unsigned WIDTH = 32,
    localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [2:0]           op_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic [2*WIDTH-1:0]   hilo_i,
    input  logic                 annul_i,
    output logic                 busy_o,
    output logic                 ready_o,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 div_zero_o
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MUL  = 3'd1;
    localparam logic [2:0] S_DIV  = 3'd2;
    localparam logic [2:0] S_ACC  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;       // {accumulate, subtract}
    logic [2*WIDTH-1:0] hilo_q, hilo_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;     // mul: {partial, multiplier}; div: {rem, quo}
    logic               neg1_q, neg1_d;
    logic               neg2_q, neg2_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               dz_q, dz_d;

    logic               in_signed, in_div, in_neg1, in_neg2;
    logic [WIDTH-1:0]   in_mag1, in_mag2;
    logic               last_step;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next, mul_fin;

    logic [WIDTH:0]     div_tmp;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem, div_quo, div_r_fin, div_q_fin;

    always_comb begin
        in_signed = ~op_i[0];
        in_div    = (op_i[2:1] == 2'b01);
        in_neg1   = in_signed & opdata1_i[WIDTH-1];
        in_neg2   = in_signed & opdata2_i[WIDTH-1];
        in_mag1   = in_neg1 ? -opdata1_i : opdata1_i;
        in_mag2   = in_neg2 ? -opdata2_i : opdata2_i;
        last_step = (cnt_q == CNT_W'(1));

        // Shift-add: the multiplier occupies the low half and is consumed LSB first.
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};
        mul_fin  = (neg1_q ^ neg2_q) ? -mul_next : mul_next;

        div_tmp   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_ge    = (div_tmp >= {1'b0, b_q});
        div_rem   = div_ge ? WIDTH'(div_tmp - {1'b0, b_q}) : div_tmp[WIDTH-1:0];
        div_quo   = {acc_q[WIDTH-2:0], div_ge};
        div_q_fin = (neg1_q ^ neg2_q) ? -div_quo : div_quo;
        div_r_fin = neg1_q ? -div_rem : div_rem;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        hilo_d   = hilo_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        neg1_d   = neg1_q;
        neg2_d   = neg2_q;
        result_d = result_q;
        dz_d     = dz_q;

        case (state_q)
            S_IDLE: begin
                if (start_i && !annul_i) begin
                    op_d   = op_i[2:1];
                    hilo_d = hilo_i;
                    a_d    = in_mag1;
                    b_d    = in_mag2;
                    neg1_d = in_neg1;
                    neg2_d = in_neg2;
                    cnt_d  = CNT_W'(WIDTH);
                    if (in_div) begin
                        acc_d = {{WIDTH{1'b0}}, in_mag1};
                        if (opdata2_i == '0) begin
                            result_d = {opdata1_i, {WIDTH{1'b1}}};
                            dz_d     = 1'b1;
                            state_d  = S_DONE;
                        end else begin
                            state_d = S_DIV;
                        end
                    end else begin
                        acc_d   = {{WIDTH{1'b0}}, in_mag2};
                        state_d = S_MUL;
                    end
                end
            end
            S_MUL: begin
                acc_d = mul_next;
                cnt_d = cnt_q - CNT_W'(1);
                if (last_step) begin
                    acc_d = mul_fin;
                    if (op_q[1]) begin
                        state_d = S_ACC;
                    end else begin
                        result_d = mul_fin;
                        dz_d     = 1'b0;
                        state_d  = S_DONE;
                    end
                end
            end
            S_ACC: begin
                result_d = op_q[0] ? hilo_q - acc_q : hilo_q + acc_q;
                dz_d     = 1'b0;
                state_d  = S_DONE;
            end
            S_DIV: begin
                acc_d = {div_rem, div_quo};
                cnt_d = cnt_q - CNT_W'(1);
                if (last_step) begin
                    result_d = {div_r_fin, div_q_fin};
                    dz_d     = 1'b0;
                    state_d  = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Annul wins over any completion write in the same cycle.
        if (annul_i && state_q != S_IDLE) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            result_d = result_q;
            dz_d     = dz_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            hilo_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            neg1_q   <= 1'b0;
            neg2_q   <= 1'b0;
            result_q <= '0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            hilo_q   <= hilo_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            neg1_q   <= neg1_d;
            neg2_q   <= neg2_d;
            result_q <= result_d;
            dz_q     <= dz_d;
        end
    end

    assign busy_o     = (state_q != S_IDLE);
    assign ready_o    = (state_q == S_DONE) && !annul_i;
    assign result_o   = result_q;
    assign div_zero_o = dz_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed scoreboard bench for mdu_iter at WIDTH=32 and WIDTH=8.
module tb_mdu_iter;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MADD  = 3'b100;
    localparam logic [2:0] OP_MSUBU = 3'b111;

    typedef struct {
        logic [63:0] res;
        logic        dz;
        int          cyc;
        int          id;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    exp_t q32[$];
    exp_t q8[$];

    logic        rst32 = 1'b0, start32 = 1'b0, annul32 = 1'b0;
    logic [2:0]  op32 = '0;
    logic [31:0] d1_32 = '0, d2_32 = '0;
    logic [63:0] h32 = '0;
    logic        busy32, ready32, dz32;
    logic [63:0] res32;

    logic        rst8 = 1'b0, start8 = 1'b0, annul8 = 1'b0;
    logic [2:0]  op8 = '0;
    logic [7:0]  d1_8 = '0, d2_8 = '0;
    logic [15:0] h8 = '0;
    logic        busy8, ready8, dz8;
    logic [15:0] res8;

    mdu_iter #(.WIDTH(32)) u32 (
        .clk(clk), .rst(rst32), .start_i(start32), .op_i(op32),
        .opdata1_i(d1_32), .opdata2_i(d2_32), .hilo_i(h32), .annul_i(annul32),
        .busy_o(busy32), .ready_o(ready32), .result_o(res32), .div_zero_o(dz32)
    );

    mdu_iter #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst8), .start_i(start8), .op_i(op8),
        .opdata1_i(d1_8), .opdata2_i(d2_8), .hilo_i(h8), .annul_i(annul8),
        .busy_o(busy8), .ready_o(ready8), .result_o(res8), .div_zero_o(dz8)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst32 === 1'b1 && ready32 === 1'b1) begin
            if (q32.size() == 0) begin
                chk("u32 unexpected ready", 64'(ready32), 64'd0);
            end else begin
                exp_t e;
                e = q32.pop_front();
                chk($sformatf("u32 op%0d result", e.id), res32, e.res);
                chk($sformatf("u32 op%0d div_zero", e.id), 64'(dz32), 64'(e.dz));
                chk($sformatf("u32 op%0d ready cycle", e.id), 64'(cyc), 64'(e.cyc));
            end
        end
        if (rst8 === 1'b1 && ready8 === 1'b1) begin
            if (q8.size() == 0) begin
                chk("u8 unexpected ready", 64'(ready8), 64'd0);
            end else begin
                exp_t e;
                e = q8.pop_front();
                chk($sformatf("u8 op%0d result", e.id), 64'(res8), e.res);
                chk($sformatf("u8 op%0d div_zero", e.id), 64'(dz8), 64'(e.dz));
                chk($sformatf("u8 op%0d ready cycle", e.id), 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic issue32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] hilo, input bit push, input logic [63:0] res,
                           input logic dz, input int lat, input int id);
        @(posedge clk); #1;
        start32 = 1'b1; op32 = op; d1_32 = a; d2_32 = b; h32 = hilo;
        if (push) q32.push_back('{res: res, dz: dz, cyc: cyc + lat, id: id});
        @(posedge clk); #1;
        start32 = 1'b0;
        d1_32 = $urandom; d2_32 = $urandom; h32 = {$urandom, $urandom};
    endtask

    task automatic issue8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] hilo, input bit push, input logic [15:0] res,
                          input logic dz, input int lat, input int id);
        @(posedge clk); #1;
        start8 = 1'b1; op8 = op; d1_8 = a; d2_8 = b; h8 = hilo;
        if (push) q8.push_back('{res: 64'(res), dz: dz, cyc: cyc + lat, id: id});
        @(posedge clk); #1;
        start8 = 1'b0;
        d1_8 = 8'($urandom); d2_8 = 8'($urandom); h8 = 16'($urandom);
    endtask

    // Counts busy cycles from the current cycle on; bounded so a stuck DUT still ends.
    task automatic wait_busy32(input int exp_n, input string tag);
        int n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (busy32 !== 1'b1) break;
            n++;
        end
        chk(tag, 64'(n), 64'(exp_n));
    endtask

    task automatic wait_busy8(input int exp_n, input string tag);
        int n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (busy8 !== 1'b1) break;
            n++;
        end
        chk(tag, 64'(n), 64'(exp_n));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset busy32", 64'(busy32), 64'd0);
        chk("reset ready32", 64'(ready32), 64'd0);
        chk("reset result32", res32, 64'd0);
        chk("reset dz32", 64'(dz32), 64'd0);
        chk("reset busy8", 64'(busy8), 64'd0);
        chk("reset result8", 64'(res8), 64'd0);
        @(posedge clk); #1;
        rst32 = 1'b1; rst8 = 1'b1;

        issue32(OP_MULT, 32'hFFFF_FFFD, 32'd7, '0, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 33, 1);
        wait_busy32(33, "MULT busy cycles");
        issue32(OP_MSUBU, 32'd3, 32'd5, 64'h10, 1'b1, 64'h1, 1'b0, 34, 2);
        wait_busy32(34, "MSUBU busy cycles");
        issue32(OP_MADD, 32'h8000_0000, 32'h8000_0000, '0, 1'b1, 64'h4000_0000_0000_0000, 1'b0, 34, 3);
        wait_busy32(34, "MADD busy cycles");
        issue32(OP_DIV, 32'hFFFF_FFF9, 32'd2, '0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 33, 4);
        wait_busy32(33, "DIV busy cycles");
        issue32(OP_DIVU, 32'hFFFF_FFF9, 32'd2, '0, 1'b1, 64'h0000_0001_7FFF_FFFC, 1'b0, 33, 5);
        wait_busy32(33, "DIVU busy cycles");
        issue32(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, '0, 1'b1, 64'h0000_0000_8000_0000, 1'b0, 33, 6);
        wait_busy32(33, "DIV overflow busy cycles");
        issue32(OP_DIVU, 32'h1234, 32'd0, '0, 1'b1, 64'h0000_1234_FFFF_FFFF, 1'b1, 1, 7);
        wait_busy32(1, "DIVU by zero busy cycles");
        issue32(OP_MULTU, 32'd2, 32'd2, '0, 1'b1, 64'd4, 1'b0, 33, 8);
        wait_busy32(33, "MULTU busy cycles");

        // Annul mid-MULT: no completion, previous result and flag retained.
        issue32(OP_MULT, 32'd11, 32'd13, '0, 1'b0, '0, 1'b0, 0, 9);
        repeat (9) @(posedge clk);
        #1 annul32 = 1'b1;
        @(posedge clk); #1;
        annul32 = 1'b0;
        @(negedge clk);
        chk("annul busy", 64'(busy32), 64'd0);
        chk("annul result held", res32, 64'd4);
        chk("annul dz held", 64'(dz32), 64'd0);

        // Start pulses while busy are dropped; exactly one completion.
        issue32(OP_MULTU, 32'd3, 32'd5, '0, 1'b1, 64'd15, 1'b0, 33, 10);
        repeat (5) @(posedge clk);
        #1 start32 = 1'b1; op32 = OP_MULTU; d1_32 = 32'd100; d2_32 = 32'd100;
        @(posedge clk); #1;
        start32 = 1'b0;
        wait_busy32(27, "busy with ignored start");

        // start together with annul in IDLE is ignored.
        @(posedge clk); #1;
        start32 = 1'b1; annul32 = 1'b1; op32 = OP_MULTU; d1_32 = 32'd7; d2_32 = 32'd7;
        @(posedge clk); #1;
        start32 = 1'b0; annul32 = 1'b0;
        @(negedge clk);
        chk("start+annul busy", 64'(busy32), 64'd0);
        chk("start+annul result", res32, 64'd15);

        issue8(OP_MULTU, 8'hFF, 8'hFF, '0, 1'b1, 16'hFE01, 1'b0, 9, 11);
        wait_busy8(9, "u8 MULTU busy cycles");
        issue8(OP_DIV, 8'h80, 8'hFF, '0, 1'b1, 16'h0080, 1'b0, 9, 12);
        wait_busy8(9, "u8 DIV busy cycles");
        issue8(OP_DIVU, 8'h12, 8'h00, '0, 1'b1, 16'h12FF, 1'b1, 1, 13);
        wait_busy8(1, "u8 DIVU by zero busy cycles");

        // Asynchronous reset in the middle of a divide clears outputs without a clock edge.
        issue8(OP_DIV, 8'h77, 8'h03, '0, 1'b0, '0, 1'b0, 0, 14);
        repeat (3) @(posedge clk);
        #3 rst8 = 1'b0;
        #1;
        chk("u8 async reset busy", 64'(busy8), 64'd0);
        chk("u8 async reset ready", 64'(ready8), 64'd0);
        chk("u8 async reset result", 64'(res8), 64'd0);
        chk("u8 async reset dz", 64'(dz8), 64'd0);
        #1 rst8 = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("u32 pending completions", 64'(q32.size()), 64'd0);
        chk("u8 pending completions", 64'(q8.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
